// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - ARM pipeline instruction fetch stage with PC, IF/ID register and fetch counter
module fetch_stage #(
   parameter int                     ADDRESS_LEN = 32,
   parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0,
   parameter int                     CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   freeze,
   input  logic                   branch_taken,
   input  logic [ADDRESS_LEN-1:0] branch_addr,
   output logic [ADDRESS_LEN-1:0] imem_addr,
   input  logic [ADDRESS_LEN-1:0] imem_rdata,
   output logic [ADDRESS_LEN-1:0] id_pc,
   output logic [ADDRESS_LEN-1:0] id_instr,
   output logic                   id_valid,
   output logic [CNT_W-1:0]       fetch_cnt
);

   logic [ADDRESS_LEN-1:0] pc_q, pc_d;
   logic [ADDRESS_LEN-1:0] id_pc_q, id_pc_d;
   logic [ADDRESS_LEN-1:0] id_instr_q, id_instr_d;
   logic                   id_valid_q, id_valid_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ADDRESS_LEN-1:0] pc_plus4;

   // Sequential PC wraps naturally at the top of the address space.
   assign pc_plus4  = pc_q + ADDRESS_LEN'(4);
   assign imem_addr = pc_q;

   // Next-state selection: redirect beats stall, stall beats normal fetch.
   always_comb begin
      pc_d       = pc_q;
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
      id_valid_d = id_valid_q;
      cnt_d      = cnt_q;
      if (branch_taken) begin
         // Target is forced word aligned; the instruction in flight is squashed.
         pc_d       = {branch_addr[ADDRESS_LEN-1:2], 2'b00};
         id_pc_d    = '0;
         id_instr_d = '0;
         id_valid_d = 1'b0;
      end else if (!freeze) begin
         pc_d       = pc_plus4;
         id_pc_d    = pc_plus4;
         id_instr_d = imem_rdata;
         id_valid_d = 1'b1;
         cnt_d      = cnt_q + CNT_W'(1);
      end
   end

   // State registers with synchronous reset that overrides stall and redirect.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         id_pc_q    <= '0;
         id_instr_q <= '0;
         id_valid_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         pc_q       <= pc_d;
         id_pc_q    <= id_pc_d;
         id_instr_q <= id_instr_d;
         id_valid_q <= id_valid_d;
         cnt_q      <= cnt_d;
      end
   end

   assign id_pc     = id_pc_q;
   assign id_instr  = id_instr_q;
   assign id_valid  = id_valid_q;
   assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector bench for fetch_stage
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_valid;
   logic [15:0] fetch_cnt;

   logic [31:0] rom [256];
   int          n_vec = 0;
   int          n_err = 0;

   typedef struct packed {
      logic        rst_n;
      logic        frz;
      logic        br;
      logic [31:0] baddr;
      logic [31:0] e_pc;
      logic [31:0] e_idpc;
      logic [31:0] e_instr;
      logic        e_v;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vt [20];

   fetch_stage #(.ADDRESS_LEN(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .id_pc        (id_pc),
      .id_instr     (id_instr),
      .id_valid     (id_valid),
      .fetch_cnt    (fetch_cnt)
   );

   always #5 clk = ~clk;

   assign imem_rdata = rom[imem_addr[9:2]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_idpc,
                          input logic [31:0] e_instr, input logic e_v, input logic [15:0] e_cnt);
      chk({tag, ".pc"},       imem_addr, e_pc);
      chk({tag, ".id_pc"},    id_pc, e_idpc);
      chk({tag, ".id_instr"}, id_instr, e_instr);
      chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, e_v});
      chk({tag, ".cnt"},      {16'd0, fetch_cnt}, {16'd0, e_cnt});
      chk({tag, ".noX"}, {31'd0, $isunknown({imem_addr, id_pc, id_instr, id_valid, fetch_cnt})}, 32'd0);
   endtask

   task automatic step(input logic r, input logic f, input logic b, input logic [31:0] a);
      @(negedge clk);
      rst_n        = r;
      freeze       = f;
      branch_taken = b;
      branch_addr  = a;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 | i;
      rom[0] = 32'hE3A0_0015;
      rom[1] = 32'hE3A0_1A01;
      rom[7] = 32'hEAFF_FFFF;

      rst_n = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;

      //         rst  frz br  baddr          pc            id_pc         id_instr      v     cnt
      vt[0]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 16'd0};
      vt[1]  = '{1'b1,1'b0,1'b0,32'h0,        32'h4,        32'h4,        32'hE3A00015, 1'b1, 16'd1};
      vt[2]  = '{1'b1,1'b0,1'b0,32'h0,        32'h8,        32'h8,        32'hE3A01A01, 1'b1, 16'd2};
      vt[3]  = '{1'b1,1'b0,1'b0,32'hDEADBEE0, 32'hC,        32'hC,        32'hA0000002, 1'b1, 16'd3};
      vt[4]  = '{1'b1,1'b0,1'b0,32'h0,        32'h10,       32'h10,       32'hA0000003, 1'b1, 16'd4};
      vt[5]  = '{1'b1,1'b1,1'b0,32'h0,        32'h10,       32'h10,       32'hA0000003, 1'b1, 16'd4};
      vt[6]  = '{1'b1,1'b1,1'b0,32'h44,       32'h10,       32'h10,       32'hA0000003, 1'b1, 16'd4};
      vt[7]  = '{1'b1,1'b1,1'b0,32'h0,        32'h10,       32'h10,       32'hA0000003, 1'b1, 16'd4};
      vt[8]  = '{1'b1,1'b0,1'b0,32'h0,        32'h14,       32'h14,       32'hA0000004, 1'b1, 16'd5};
      vt[9]  = '{1'b1,1'b0,1'b1,32'h1C,       32'h1C,       32'h0,        32'h0,        1'b0, 16'd5};
      vt[10] = '{1'b1,1'b0,1'b0,32'h0,        32'h20,       32'h20,       32'hEAFFFFFF, 1'b1, 16'd6};
      vt[11] = '{1'b1,1'b1,1'b1,32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 16'd6};
      vt[12] = '{1'b1,1'b0,1'b0,32'h0,        32'h4,        32'h4,        32'hE3A00015, 1'b1, 16'd7};
      vt[13] = '{1'b1,1'b0,1'b1,32'h13,       32'h10,       32'h0,        32'h0,        1'b0, 16'd7};
      vt[14] = '{1'b1,1'b0,1'b0,32'h0,        32'h14,       32'h14,       32'hA0000004, 1'b1, 16'd8};
      vt[15] = '{1'b1,1'b1,1'b0,32'h0,        32'h14,       32'h14,       32'hA0000004, 1'b1, 16'd8};
      vt[16] = '{1'b0,1'b1,1'b0,32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 16'd0};
      vt[17] = '{1'b1,1'b0,1'b1,32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b0, 16'd0};
      vt[18] = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        32'h0,        32'hA00000FF, 1'b1, 16'd1};
      vt[19] = '{1'b1,1'b0,1'b0,32'h0,        32'h4,        32'h4,        32'hE3A00015, 1'b1, 16'd2};

      for (int i = 0; i < 20; i++) begin
         step(vt[i].rst_n, vt[i].frz, vt[i].br, vt[i].baddr);
         chk_all($sformatf("v%0d", i), vt[i].e_pc, vt[i].e_idpc, vt[i].e_instr, vt[i].e_v, vt[i].e_cnt);
      end

      // Back-to-back redirects: only the second target survives, counter untouched.
      step(1'b1, 1'b0, 1'b1, 32'h40);
      chk_all("bb1", 32'h40, 32'h0, 32'h0, 1'b0, 16'd2);
      step(1'b1, 1'b0, 1'b1, 32'h83);
      chk_all("bb2", 32'h80, 32'h0, 32'h0, 1'b0, 16'd2);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk_all("bb3", 32'h84, 32'h84, 32'hA0000020, 1'b1, 16'd3);

      // Reset asserted together with a redirect: reset wins.
      step(1'b0, 1'b1, 1'b1, 32'h100);
      chk_all("rbr", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
      step(1'b1, 1'b0, 1'b0, 32'h0);
      chk_all("rbr1", 32'h4, 32'h4, 32'hE3A00015, 1'b1, 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
